// File: rtl/sasa_match_pkg.sv
// ============================================================================
// Module  : sasa_match_pkg
// Purpose : Shared widths, iterator state encoding and one-hot→index helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SASA_CAM_len
`define SASA_CAM_len 256
`endif

package sasa_match_pkg;

  localparam int CAM_LEN = `SASA_CAM_len;
  localparam int IDX_W   = $clog2(CAM_LEN);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } iterState_e;

  // Input is assumed one-hot (or zero); a zero vector maps to index 0.
  function automatic logic [IDX_W-1:0] onehotToIdx(input logic [CAM_LEN-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < CAM_LEN; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/match_prio_sel.sv
// ============================================================================
// Module  : match_prio_sel
// Purpose : Combinational MSB-first one-hot select and index encode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module match_prio_sel
  import sasa_match_pkg::*;
(
  input  logic [CAM_LEN-1:0] vec,
  output logic [CAM_LEN-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin : g_prioScan
    logic w_seen;
    onehot = '0;
    w_seen = 1'b0;
    // Walk from the top; the first set bit masks all lower ones.
    for (int i = CAM_LEN - 1; i >= 0; i--) begin
      onehot[i] = vec[i] & ~w_seen;
      w_seen    = w_seen | vec[i];
    end
  end

  assign idx = onehotToIdx(onehot);

endmodule

`default_nettype wire

// File: rtl/match_iterator.sv
// ============================================================================
// Module  : match_iterator
// Purpose : Emits the indices of a CAM match vector one beat at a time,
//           highest index first. Optional out_seq ordinal: MATCH_ITER_SEQ_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module match_iterator
  import sasa_match_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CAM_LEN-1:0] in_vec,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [CAM_LEN-1:0] out_onehot,
  output logic               out_last,
  output logic               out_empty
`ifdef MATCH_ITER_SEQ_EN
  ,
  output logic [IDX_W:0]     out_seq
`endif
);

  localparam logic [0:0] c_STATE_IDLE = IDLE;
  localparam logic [0:0] c_STATE_ITER = ITER;

  logic [0:0]         r_state;
  logic [CAM_LEN-1:0] r_remVec;
  logic [CAM_LEN-1:0] w_selOnehot;
  logic [IDX_W-1:0]   w_selIdx;
  logic               w_iter;
  logic               w_atMostOne;
  logic               w_outFire;

  match_prio_sel u_prioSel (
    .vec    (r_remVec),
    .onehot (w_selOnehot),
    .idx    (w_selIdx)
  );

  assign w_iter      = (r_state == c_STATE_ITER);
  // Clearing the lowest set bit leaves zero iff at most one bit was set.
  assign w_atMostOne = ((r_remVec & (r_remVec - CAM_LEN'(1))) == '0);
  assign w_outFire   = out_valid & out_ready;

  assign in_ready   = ~w_iter;
  assign out_valid  = w_iter;
  assign out_idx    = w_iter ? w_selIdx : '0;
  assign out_onehot = w_iter ? w_selOnehot : '0;
  assign out_last   = w_iter & w_atMostOne;
  assign out_empty  = w_iter & (r_remVec == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state  <= c_STATE_IDLE;
      r_remVec <= '0;
    end else begin
      case (r_state)
        c_STATE_IDLE: begin
          if (in_valid) begin
            r_remVec <= in_vec;
            r_state  <= c_STATE_ITER;
          end
        end
        c_STATE_ITER: begin
          if (w_outFire) begin
            r_remVec <= r_remVec & ~w_selOnehot;
            if (out_last) r_state <= c_STATE_IDLE;
          end
        end
        default: begin
          r_state  <= c_STATE_IDLE;
          r_remVec <= '0;
        end
      endcase
    end
  end

`ifdef MATCH_ITER_SEQ_EN
  logic [IDX_W:0] r_seq;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_seq <= '0;
    end else if (in_valid && in_ready) begin
      r_seq <= '0;
    end else if (w_outFire) begin
      r_seq <= r_seq + (IDX_W + 1)'(1);
    end
  end

  assign out_seq = r_seq;
`endif

endmodule

`default_nettype wire

// File: doc/match_iterator.md
MATCH_ITERATOR -- requirements
Module: match_iterator

Interface
REQ-001 The block SHALL use the global macro SASA_CAM_len (default 256) as the match-vector width, with IDX_W = log2(SASA_CAM_len) (8 at default) as the index width.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, providing a synchronous, active-low reset.
REQ-004 The port in_valid SHALL be an input, 1 bit wide, and SHALL indicate that a CAM OR match vector is presented.
REQ-005 The port in_ready SHALL be an output, 1 bit wide, and SHALL indicate that the block can accept a vector.
REQ-006 The port in_vec SHALL be an input, SASA_CAM_len bits wide, carrying the raw CAM match vector.
REQ-007 The port flush SHALL be an input, 1 bit wide, and SHALL abort the current iteration.
REQ-008 The port out_valid SHALL be an output, 1 bit wide, and SHALL indicate that an index beat is valid.
REQ-009 The port out_ready SHALL be an input, 1 bit wide, carrying downstream acceptance.
REQ-010 The port out_idx SHALL be an output, IDX_W bits wide, carrying the index of the highest remaining set bit.
REQ-011 The port out_onehot SHALL be an output, SASA_CAM_len bits wide, carrying the one-hot form of out_idx.
REQ-012 The port out_last SHALL be an output, 1 bit wide, and SHALL mark the final beat for the current vector.
REQ-013 The port out_empty SHALL be an output, 1 bit wide, and SHALL mark that the loaded vector had no set bits.

Function
REQ-014 The state machine SHALL have exactly two states: IDLE and ITER.
REQ-015 In IDLE, the block SHALL drive in_ready=1 and out_valid=0.
REQ-016 In ITER, the block SHALL drive in_ready=0.
REQ-017 When in_valid&in_ready, the block SHALL register in_vec into rem_vec and enter ITER.
REQ-018 Load-to-first-beat latency SHALL be 1 cycle: out_valid=1 in the cycle after acceptance.
REQ-019 In ITER, out_idx and out_onehot SHALL be combinational from rem_vec and SHALL select the highest set bit (MSB-first priority).
REQ-020 Beats SHALL therefore be emitted in strictly descending index order.
REQ-021 On out_valid&out_ready, the block SHALL clear the selected bit in rem_vec.
REQ-022 out_last SHALL be 1 when rem_vec has exactly one set bit.
REQ-023 On a handshake with out_last=1, the block SHALL return to IDLE, and in_ready SHALL rise the next cycle.
REQ-024 With out_valid=1 and out_ready=0, out_idx, out_onehot, out_last and out_empty SHALL hold stable.
REQ-025 A zero vector SHALL produce exactly one beat with out_empty=1, out_last=1, out_idx=0 and out_onehot=0, then return to IDLE.
REQ-026 A full vector (all ones) SHALL produce SASA_CAM_len beats, indices 255 down to 0.
REQ-027 flush=1 SHALL force IDLE and clear rem_vec on the next edge, discarding any pending beat.
REQ-028 A simultaneous flush and out handshake SHALL have no effect beyond the flush.
REQ-029 flush SHALL take priority over in_valid.
REQ-030 The block SHALL accept no new vector in the same cycle as the last handshake (no back-to-back bypass), so the minimum period is N+1 cycles for N beats.

Reset
REQ-031 While rst_n=0 at a clk edge, the block SHALL set state=IDLE and rem_vec=0.
REQ-032 After reset, the outputs SHALL be in_ready=1, out_valid=0, out_idx=0, out_onehot=0, out_last=0 and out_empty=0.
REQ-033 A reset mid-iteration SHALL discard the vector without emitting a further beat.

Configuration
REQ-034 When MATCH_ITER_SEQ_EN is defined, the block SHALL add the output out_seq [IDX_W:0], the 0-based ordinal of the current beat within the vector.
REQ-035 out_seq SHALL be reset to 0 by reset, flush or vector load, and SHALL increment per handshake.
REQ-036 out_seq SHALL read 0 on a zero-vector beat.
REQ-037 When MATCH_ITER_SEQ_EN is undefined, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-038 A shared package sasa_match_pkg SHALL hold the state enum (IDLE, ITER), IDX_W, and a one-hot-to-index function.
REQ-039 One sub-module, match_prio_sel, SHALL provide the combinational MSB-first one-hot select and index encode; the FSM, rem_vec and the counter SHALL stay in match_iterator.

Verification
REQ-040 The bench SHALL cover: load 0x...0000_8001 with out_ready=1 -> beats idx 15 then idx 0, last on the 2nd beat, in_ready=1 on cycle 4.
REQ-041 The bench SHALL cover: load a zero vector -> a single beat with out_empty=1, out_last=1, idx=0.
REQ-042 The bench SHALL cover: load bits {200,100,3} with out_ready low for 3 cycles -> idx 200 held stable, then 200, 100, 3 in order.
REQ-043 The bench SHALL cover: load all ones -> 256 beats, 255 down to 0, out_last only on idx 0, and with MATCH_ITER_SEQ_EN out_seq reaching 255.
REQ-044 The bench SHALL cover: flush asserted after the 1st of 3 beats -> next cycle IDLE, out_valid=0, and a new vector loads cleanly.
REQ-045 The bench SHALL cover: rst_n=0 for one cycle during ITER -> all outputs at reset values the next cycle, with no stale beats.
